// File: rtl/axi_cdc_sleep_ctrl.sv
// Master-domain sleep controller placed behind the dual-clock AXI crossing.
// It counts in-flight AXI transactions, drains them, waits for a quiet period,
// then gates the master clock. Incoming traffic or a withdrawn request wakes it.
// It runs on the free-running master clock.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_RUN     | normal operation, crossing open
//   ST_DRAIN   | isolated, waiting for the outstanding count to reach zero
//   ST_IDLE_WAIT | isolated, counting quiet cycles before gating
//   ST_SLEEP   | isolated and clock gated, sleep acknowledged
//   ST_WAKE    | clock running again, isolation held while the domain settles
module axi_cdc_sleep_ctrl #(
    parameter int MAX_OUTSTANDING = 16,
    parameter int IDLE_CYCLES     = 8,
    parameter int WAKE_CYCLES     = 4,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             sleep_req_i,
    input  logic             incoming_req_i,
    input  logic             aw_valid_i,
    input  logic             aw_ready_i,
    input  logic             ar_valid_i,
    input  logic             ar_ready_i,
    input  logic             b_valid_i,
    input  logic             b_ready_i,
    input  logic             r_valid_i,
    input  logic             r_ready_i,
    input  logic             r_last_i,
    output logic             isolate_o,
    output logic             clock_down_o,
    output logic             sleep_ack_o,
    output logic [CNT_W-1:0] outstanding_o,
    output logic             err_o
);

    localparam int T_MAX = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
    localparam int TMR_W = $clog2(T_MAX + 1);
    localparam logic [TMR_W-1:0] IDLE_LAST = TMR_W'(IDLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] WAKE_LAST = TMR_W'(WAKE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_DRAIN,
        ST_IDLE_WAIT,
        ST_SLEEP,
        ST_WAKE
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             cnt_bad;
    logic             aw_hs, ar_hs, b_hs, r_last_hs, any_hs;
    logic [1:0]       inc, dec;
    int               cnt_sum;

    assign aw_hs     = aw_valid_i & aw_ready_i;
    assign ar_hs     = ar_valid_i & ar_ready_i;
    assign b_hs      = b_valid_i & b_ready_i;
    assign r_last_hs = r_valid_i & r_ready_i & r_last_i;
    // A non-last R beat still counts as bus activity for the drain exit.
    assign any_hs    = aw_hs | ar_hs | b_hs | (r_valid_i & r_ready_i);

    assign outstanding_o = cnt;

    // Net counter change for this cycle, clamped to 0..MAX_OUTSTANDING.
    always_comb begin
        inc     = {1'b0, aw_hs} + {1'b0, ar_hs};
        dec     = {1'b0, b_hs} + {1'b0, r_last_hs};
        cnt_sum = int'(cnt) + int'(inc) - int'(dec);
        cnt_nxt = cnt;
        cnt_bad = 1'b0;
        if (cnt_sum > MAX_OUTSTANDING) begin
            cnt_nxt = CNT_W'(MAX_OUTSTANDING);
            cnt_bad = 1'b1;
        end else if (cnt_sum < 0) begin
            cnt_nxt = '0;
            cnt_bad = 1'b1;
        end else begin
            cnt_nxt = CNT_W'(cnt_sum);
        end
    end

    // Outstanding counter with sticky overflow/underflow flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt   <= '0;
            err_o <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (cnt_bad) begin
                err_o <= 1'b1;
            end
        end
    end

    // Sequencing FSM; outputs are registered alongside each state change.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= ST_RUN;
            timer        <= '0;
            isolate_o    <= 1'b0;
            clock_down_o <= 1'b0;
            sleep_ack_o  <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (sleep_req_i && !incoming_req_i) begin
                        state     <= ST_DRAIN;
                        isolate_o <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!sleep_req_i) begin
                        state     <= ST_RUN;
                        isolate_o <= 1'b0;
                    end else if (cnt == '0 && !any_hs) begin
                        state <= ST_IDLE_WAIT;
                        timer <= '0;
                    end
                end
                ST_IDLE_WAIT: begin
                    if (!sleep_req_i || incoming_req_i) begin
                        state     <= ST_RUN;
                        isolate_o <= 1'b0;
                    end else if (any_hs) begin
                        state <= ST_DRAIN;
                    end else if (timer == IDLE_LAST) begin
                        state        <= ST_SLEEP;
                        clock_down_o <= 1'b1;
                        sleep_ack_o  <= 1'b1;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ST_SLEEP: begin
                    if (incoming_req_i || !sleep_req_i) begin
                        state        <= ST_WAKE;
                        timer        <= '0;
                        clock_down_o <= 1'b0;
                        sleep_ack_o  <= 1'b0;
                    end
                end
                ST_WAKE: begin
                    if (timer == WAKE_LAST) begin
                        state     <= ST_RUN;
                        isolate_o <= 1'b0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: begin
                    state        <= ST_RUN;
                    timer        <= '0;
                    isolate_o    <= 1'b0;
                    clock_down_o <= 1'b0;
                    sleep_ack_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_cdc_sleep_ctrl.sv
// Bench for axi_cdc_sleep_ctrl: random handshake traffic against an integer
// counter model, then directed sleep/wake timing sequences.
module tb_axi_cdc_sleep_ctrl;

    localparam int MAX_OUT = 16;
    localparam int IDLE    = 8;
    localparam int WAKE    = 4;
    localparam int CNT_W   = $clog2(MAX_OUT + 1);

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic sleep_req_i = 1'b0, incoming_req_i = 1'b0;
    logic aw_valid_i = 1'b0, aw_ready_i = 1'b0, ar_valid_i = 1'b0, ar_ready_i = 1'b0;
    logic b_valid_i = 1'b0, b_ready_i = 1'b0;
    logic r_valid_i = 1'b0, r_ready_i = 1'b0, r_last_i = 1'b0;
    logic isolate_o, clock_down_o, sleep_ack_o, err_o;
    logic [CNT_W-1:0] outstanding_o;

    int errors = 0;
    int checks = 0;
    int cnt_m  = 0;
    bit err_m  = 1'b0;
    bit cd_seen = 1'b0;

    always #5 clk_i = ~clk_i;

    axi_cdc_sleep_ctrl #(
        .MAX_OUTSTANDING(MAX_OUT),
        .IDLE_CYCLES    (IDLE),
        .WAKE_CYCLES    (WAKE)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .sleep_req_i   (sleep_req_i),
        .incoming_req_i(incoming_req_i),
        .aw_valid_i    (aw_valid_i),
        .aw_ready_i    (aw_ready_i),
        .ar_valid_i    (ar_valid_i),
        .ar_ready_i    (ar_ready_i),
        .b_valid_i     (b_valid_i),
        .b_ready_i     (b_ready_i),
        .r_valid_i     (r_valid_i),
        .r_ready_i     (r_ready_i),
        .r_last_i      (r_last_i),
        .isolate_o     (isolate_o),
        .clock_down_o  (clock_down_o),
        .sleep_ack_o   (sleep_ack_o),
        .outstanding_o (outstanding_o),
        .err_o         (err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit aw, input bit ar, input bit b, input bit r, input bit rl);
        aw_valid_i = aw; aw_ready_i = aw;
        ar_valid_i = ar; ar_ready_i = ar;
        b_valid_i  = b;  b_ready_i  = b;
        r_valid_i  = r;  r_ready_i  = r;
        r_last_i   = rl;
    endtask

    // One clock: the model applies this cycle's handshakes, then the DUT is checked.
    task automatic tick();
        int d;
        d = 0;
        if (aw_valid_i && aw_ready_i) d++;
        if (ar_valid_i && ar_ready_i) d++;
        if (b_valid_i && b_ready_i) d--;
        if (r_valid_i && r_ready_i && r_last_i) d--;
        @(posedge clk_i);
        #1;
        cnt_m = cnt_m + d;
        if (cnt_m > MAX_OUT) begin
            cnt_m = MAX_OUT;
            err_m = 1'b1;
        end else if (cnt_m < 0) begin
            cnt_m = 0;
            err_m = 1'b1;
        end
        if (clock_down_o === 1'b1) cd_seen = 1'b1;
        chk("outstanding", 32'(outstanding_o), 32'(cnt_m));
        chk("err", 32'(err_o), 32'(err_m));
        chk("iso_covers_cd", 32'(clock_down_o & ~isolate_o), 32'd0);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        sleep_req_i    = 1'b0;
        incoming_req_i = 1'b0;
        rst_ni         = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        cnt_m   = 0;
        err_m   = 1'b0;
        cd_seen = 1'b0;
        chk("rst_isolate", 32'(isolate_o), 32'd0);
        chk("rst_clock_down", 32'(clock_down_o), 32'd0);
        chk("rst_sleep_ack", 32'(sleep_ack_o), 32'd0);
        chk("rst_outstanding", 32'(outstanding_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        rst_ni = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Random handshake traffic in RUN against the counter model.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            aw_valid_i = 1'($urandom_range(0, 1)); aw_ready_i = 1'($urandom_range(0, 1));
            ar_valid_i = 1'($urandom_range(0, 1)); ar_ready_i = 1'($urandom_range(0, 1));
            b_valid_i  = 1'($urandom_range(0, 1)); b_ready_i  = 1'($urandom_range(0, 1));
            r_valid_i  = 1'($urandom_range(0, 1)); r_ready_i  = 1'($urandom_range(0, 1));
            r_last_i   = 1'($urandom_range(0, 1));
            tick();
            chk("run_isolate", 32'(isolate_o), 32'd0);
        end

        // Sleep with nothing outstanding: isolate at +1, gated at +10.
        do_reset();
        sleep_req_i = 1'b1;
        tick();
        chk("iso_at_req_p1", 32'(isolate_o), 32'd1);
        chk("cd_at_req_p1", 32'(clock_down_o), 32'd0);
        for (int k = 2; k <= IDLE + 2; k++) begin
            tick();
            chk("idle_isolate", 32'(isolate_o), 32'd1);
            chk("idle_clock_down", 32'(clock_down_o), (k == IDLE + 2) ? 32'd1 : 32'd0);
            chk("idle_sleep_ack", 32'(sleep_ack_o), (k == IDLE + 2) ? 32'd1 : 32'd0);
        end

        // Wake on an incoming pulse; sleep_req still high so it re-drains.
        incoming_req_i = 1'b1;
        tick();
        incoming_req_i = 1'b0;
        chk("wake_cd_m1", 32'(clock_down_o), 32'd0);
        chk("wake_ack_m1", 32'(sleep_ack_o), 32'd0);
        chk("wake_iso_m1", 32'(isolate_o), 32'd1);
        for (int k = 2; k <= WAKE + 1; k++) begin
            tick();
            chk("wake_isolate", 32'(isolate_o), (k == WAKE + 1) ? 32'd0 : 32'd1);
        end
        tick();
        chk("redrain_isolate", 32'(isolate_o), 32'd1);
        repeat (IDLE) begin
            tick();
            chk("redrain_cd_low", 32'(clock_down_o), 32'd0);
        end
        tick();
        chk("resleep_cd", 32'(clock_down_o), 32'd1);

        // Wake with incoming held high: stays in RUN afterwards.
        incoming_req_i = 1'b1;
        tick();
        chk("wake2_cd", 32'(clock_down_o), 32'd0);
        repeat (WAKE - 1) tick();
        chk("wake2_iso_held", 32'(isolate_o), 32'd1);
        tick();
        chk("wake2_iso_release", 32'(isolate_o), 32'd0);
        repeat (4) begin
            tick();
            chk("hold_run_iso", 32'(isolate_o), 32'd0);
            chk("hold_run_cd", 32'(clock_down_o), 32'd0);
        end

        // Drain 5 outstanding transactions before gating.
        do_reset();
        drive(1, 0, 0, 0, 0); repeat (3) tick();
        drive(0, 1, 0, 0, 0); repeat (2) tick();
        drive(0, 0, 0, 0, 0);
        sleep_req_i = 1'b1;
        tick();
        chk("drain_iso", 32'(isolate_o), 32'd1);
        chk("drain_cnt", 32'(outstanding_o), 32'd5);
        repeat (3) begin
            tick();
            chk("drain_hold_cd", 32'(clock_down_o), 32'd0);
            chk("drain_hold_cnt", 32'(outstanding_o), 32'd5);
        end
        drive(0, 0, 1, 0, 0); repeat (3) tick();
        drive(0, 0, 0, 1, 1); repeat (2) tick();
        drive(0, 0, 0, 0, 0);
        chk("drained_cnt", 32'(outstanding_o), 32'd0);
        repeat (IDLE) begin
            tick();
            chk("drained_cd_low", 32'(clock_down_o), 32'd0);
        end
        tick();
        chk("drained_cd", 32'(clock_down_o), 32'd1);
        chk("drained_ack", 32'(sleep_ack_o), 32'd1);
        sleep_req_i = 1'b0;
        tick();
        chk("unreq_cd", 32'(clock_down_o), 32'd0);
        repeat (WAKE - 1) tick();
        chk("unreq_iso_held", 32'(isolate_o), 32'd1);
        tick();
        chk("unreq_iso_release", 32'(isolate_o), 32'd0);

        // Counter boundaries.
        do_reset();
        drive(1, 0, 0, 0, 0); repeat (2) tick();
        drive(0, 0, 0, 1, 0); tick();
        chk("r_nonlast_cnt", 32'(outstanding_o), 32'd2);
        drive(1, 0, 1, 0, 0); tick();
        chk("aw_b_cancel", 32'(outstanding_o), 32'd2);
        drive(1, 0, 0, 0, 0); repeat (13) tick();
        chk("cnt_15", 32'(outstanding_o), 32'd15);
        chk("cnt_15_err", 32'(err_o), 32'd0);
        drive(1, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
        chk("ovf_cnt", 32'(outstanding_o), 32'd16);
        chk("ovf_err", 32'(err_o), 32'd1);
        do_reset();
        drive(0, 0, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
        chk("unf_cnt", 32'(outstanding_o), 32'd0);
        chk("unf_err", 32'(err_o), 32'd1);

        // Request withdrawn mid-IDLE_WAIT at timer 3.
        do_reset();
        sleep_req_i = 1'b1;
        repeat (5) tick();
        sleep_req_i = 1'b0;
        tick();
        chk("abort_iso", 32'(isolate_o), 32'd0);
        repeat (3) begin
            tick();
            chk("abort_iso_stay", 32'(isolate_o), 32'd0);
        end
        chk("abort_cd_never", 32'(cd_seen), 32'd0);

        // Asynchronous reset while gated.
        do_reset();
        sleep_req_i = 1'b1;
        repeat (IDLE + 2) tick();
        chk("pre_rst_cd", 32'(clock_down_o), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_isolate", 32'(isolate_o), 32'd0);
        chk("arst_clock_down", 32'(clock_down_o), 32'd0);
        chk("arst_sleep_ack", 32'(sleep_ack_o), 32'd0);
        chk("arst_outstanding", 32'(outstanding_o), 32'd0);
        chk("arst_err", 32'(err_o), 32'd0);
        sleep_req_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        cnt_m  = 0;
        err_m  = 1'b0;
        tick();
        chk("post_rst_iso", 32'(isolate_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_cdc_sleep_ctrl.md
# axi_cdc_sleep_ctrl

Master-domain power controller that sits directly downstream of the dual-clock AXI crossing. It consumes the crossing's `incoming_req` indication and the master-side AXI handshakes, and produces its `isolate` and `clock_down` controls. It drains outstanding transactions, waits for a quiet period, requests clock gating, and wakes on incoming traffic. The block runs on the free-running master clock, never on the gated clock.

## Interface
Parameters:
- `MAX_OUTSTANDING`, 16: maximum in-flight transactions, reads plus writes; counter width is `$clog2(MAX_OUTSTANDING+1)`.
- `IDLE_CYCLES`, 8: quiet cycles required before gating; must be ≥1.
- `WAKE_CYCLES`, 4: cycles between clock ungating and isolation release; must be ≥1.

Ports:
- `clk_i` in 1: free-running master-domain clock.
- `rst_ni` in 1: reset; one clock, asynchronous, active-low.
- `sleep_req_i` in 1: level request from the power manager to gate the master domain.
- `incoming_req_i` in 1: connected to `incoming_req_master_o` of the crossing; high means a request is pending.
- `aw_valid_i`, `aw_ready_i` in 1 each: master-side AW handshake.
- `ar_valid_i`, `ar_ready_i` in 1 each: master-side AR handshake.
- `b_valid_i`, `b_ready_i` in 1 each: master-side B handshake.
- `r_valid_i`, `r_ready_i`, `r_last_i` in 1 each: master-side R handshake and last beat.
- `isolate_o` out 1: drives `isolate_master_i` of the crossing.
- `clock_down_o` out 1: drives `clock_down_master_i` of the crossing.
- `sleep_ack_o` out 1: high while the domain is gated.
- `outstanding_o` out CNT_W: current in-flight count.
- `err_o` out 1: sticky flag for counter overflow or underflow.

## Operation
- Outstanding counter:
  - +1 on an AW handshake; +1 on an AR handshake.
  - −1 on a B handshake; −1 on an R handshake with `r_last_i`.
  - The net change is applied in one cycle, range −2..+2; simultaneous increment and decrement cancel.
  - An increment beyond `MAX_OUTSTANDING` or a decrement below 0 is clamped to the bound and sets `err_o`.
  - `err_o` clears only on reset.
- FSM states, with transitions evaluated on registered state:
  - RUN: go to DRAIN when `sleep_req_i && !incoming_req_i`; otherwise stay.
  - DRAIN: `isolate_o`=1.
    - `!sleep_req_i` → RUN.
    - `outstanding==0` and no handshake of any kind this cycle → IDLE_WAIT, timer cleared.
  - IDLE_WAIT: `isolate_o`=1; the timer increments every cycle.
    - `!sleep_req_i` or `incoming_req_i` → RUN.
    - Any handshake → DRAIN.
    - `timer==IDLE_CYCLES-1` → SLEEP.
  - SLEEP: `isolate_o`=1, `clock_down_o`=1, `sleep_ack_o`=1.
    - `incoming_req_i` or `!sleep_req_i` → WAKE, timer cleared.
  - WAKE: `isolate_o`=1, `clock_down_o`=0. At `timer==WAKE_CYCLES-1` → RUN.
- Priority within a state: the exit on `sleep_req_i` deassertion or `incoming_req_i` is checked before the timer exit.
- All outputs are decoded from registered state and counters; there are no combinational input-to-output paths.

## Timing
- Reset values: state RUN; timer 0; counter 0; `isolate_o`=0, `clock_down_o`=0, `sleep_ack_o`=0, `outstanding_o`=0, `err_o`=0. Reset is honoured mid-sequence from any state, including SLEEP.
- `sleep_req_i` rising in RUN at cycle N → `isolate_o` high at N+1.
- Counter reaching 0 in DRAIN at cycle N → IDLE_WAIT at N+1 → `clock_down_o` and `sleep_ack_o` high at N+IDLE_CYCLES+1.
- `incoming_req_i` sampled in SLEEP at cycle M → `clock_down_o` and `sleep_ack_o` low at M+1 → `isolate_o` low at M+WAKE_CYCLES+1.
- `isolate_o` is never low while `clock_down_o` is high, and it never falls before WAKE has completed.
- A handshake and a counter update in the same cycle: the counter reflects the change at the next edge. DRAIN exits only on the registered zero with no concurrent handshake.

## Test plan
- Reset, then `sleep_req_i`=1 with 0 outstanding → `isolate_o`=1 at +1. With IDLE_CYCLES=8, `clock_down_o`=1 and `sleep_ack_o`=1 at +10 after request.
- Issue 3 AW and 2 AR handshakes, then assert `sleep_req_i` → remain in DRAIN with `outstanding_o`=5. After 3 B handshakes and 2 R handshakes with `r_last_i`, `clock_down_o` rises IDLE_CYCLES+1 cycles after the count reaches 0.
- In SLEEP, pulse `incoming_req_i` at cycle M → `clock_down_o`=0 at M+1; with WAKE_CYCLES=4, `isolate_o`=0 at M+5. If `incoming_req_i` stays high, the FSM stays in RUN.
- Same-cycle AW and B handshakes at count 2 → count remains 2. Same-cycle AW and AR at count 15 with MAX_OUTSTANDING=16 → count 16 and `err_o`=1. A B handshake at count 0 → count 0 and `err_o`=1.
- `sleep_req_i` dropped mid-IDLE_WAIT at timer=3 → RUN next cycle, `isolate_o`=0, `clock_down_o` never asserted. `rst_ni` asserted in SLEEP → all outputs 0 asynchronously.
